// File: rtl/lisnoc_router_output_port.sv
// lisnoc_router_output_port
//
// Transmit side of a router port. For every virtual channel an arbiter
// grants one of the competing input ports. A HEADER grant locks the channel
// to that port until its LAST flit. Granted flits go into a per-vchannel
// FIFO. A link scheduler serialises the FIFO heads onto the single outgoing
// link, rotating round-robin over the vchannels on every flit.
//
// Parameters:
//   flit_data_width  payload bits per flit
//   flit_type_width  type bits (flit = {type, data}, type in MSBs)
//   vchannels        number of virtual channels
//   ports            number of input ports competing for this output
//   fifo_length      FIFO depth per vchannel (>= 2)
//
// Ports:
//   clk             rising-edge clock
//   rst             asynchronous active-low reset
//   switch_request  request of input p on vchannel v, bit v*ports+p
//   switch_flit     flit of input p on vchannel v, slice v*ports+p
//   switch_read     combinational accept strobe, same indexing
//   link_flit       flit presented on the link
//   link_valid      one-hot (or zero) valid per vchannel
//   link_ready      downstream ready per vchannel
//   protocol_error  sticky framing error per vchannel
//
// Optional feature: define LISNOC_ROUTER_OUTPUT_CHECK_EN to build the framing
// checker. When the macro is undefined, protocol_error is tied to 0.

module lisnoc_router_output_port #(
    parameter int flit_data_width = 32,
    parameter int flit_type_width = 2,
    parameter int vchannels       = 1,
    parameter int ports           = 5,
    parameter int fifo_length     = 4
) (
    input  logic                                                         clk,
    input  logic                                                         rst,
    input  logic [ports*vchannels-1:0]                                   switch_request,
    input  logic [(flit_data_width+flit_type_width)*ports*vchannels-1:0] switch_flit,
    output logic [ports*vchannels-1:0]                                   switch_read,
    output logic [flit_data_width+flit_type_width-1:0]                   link_flit,
    output logic [vchannels-1:0]                                         link_valid,
    input  logic [vchannels-1:0]                                         link_ready,
    output logic [vchannels-1:0]                                         protocol_error
);

    localparam int flit_width = flit_data_width + flit_type_width;
    localparam int pw = (ports > 1) ? $clog2(ports) : 1;
    localparam int vw = (vchannels > 1) ? $clog2(vchannels) : 1;
    localparam int aw = (fifo_length > 1) ? $clog2(fifo_length) : 1;
    localparam int cw = $clog2(fifo_length + 1);

    localparam int unsigned n_ports = ports;
    localparam int unsigned n_vch   = vchannels;
    localparam int unsigned n_fw    = flit_width;
    localparam int unsigned n_depth = fifo_length;

    localparam logic [flit_type_width-1:0] FT_HEADER = flit_type_width'(1);
    localparam logic [flit_type_width-1:0] FT_LAST   = flit_type_width'(2);

    typedef enum logic {
        IDLE,
        LOCKED
    } arb_state_t;

    arb_state_t                 state      [vchannels];
    arb_state_t                 state_nxt  [vchannels];
    logic [pw-1:0]              owner      [vchannels];
    logic [pw-1:0]              owner_nxt  [vchannels];
    logic [pw-1:0]              last       [vchannels];
    logic [pw-1:0]              last_nxt   [vchannels];
    logic [pw-1:0]              grant_port [vchannels];
    logic [flit_width-1:0]      grant_flit [vchannels];
    logic [flit_type_width-1:0] grant_type [vchannels];
    logic [vchannels-1:0]       grant;

    logic [flit_width-1:0] mem    [vchannels][fifo_length];
    logic [aw-1:0]         rd_ptr [vchannels];
    logic [aw-1:0]         wr_ptr [vchannels];
    logic [cw-1:0]         count  [vchannels];
    logic [vchannels-1:0]  full;
    logic [vchannels-1:0]  nonempty;
    logic [vchannels-1:0]  pop;

    logic [vw-1:0] cur;
    logic [vw-1:0] cur_nxt;

    // Fill level comes from the registered count only, so a pop in the same
    // cycle never frees space for a write.
    always_comb begin
        full     = '0;
        nonempty = '0;
        for (int unsigned v = 0; v < n_vch; v++) begin
            full[v]     = (count[v] == cw'(fifo_length));
            nonempty[v] = (count[v] != '0);
        end
    end

    // Arbiter next-state and switch_read strobes.
    always_comb begin : arbiter
        int unsigned idx;
        logic        hit;
        idx         = 0;
        hit         = 1'b0;
        switch_read = '0;
        grant       = '0;
        for (int unsigned v = 0; v < n_vch; v++) begin
            state_nxt[v]  = state[v];
            owner_nxt[v]  = owner[v];
            last_nxt[v]   = last[v];
            grant_port[v] = '0;
            hit           = 1'b0;
            if (rst && !full[v]) begin
                if (state[v] == IDLE) begin
                    // First requester strictly after the last grant, cyclically.
                    for (int unsigned k = 1; k <= n_ports; k++) begin
                        idx = (32'(last[v]) + k) % n_ports;
                        if (!hit && switch_request[v*n_ports + idx]) begin
                            hit           = 1'b1;
                            grant_port[v] = pw'(idx);
                        end
                    end
                end else begin
                    hit           = switch_request[v*n_ports + 32'(owner[v])];
                    grant_port[v] = owner[v];
                end
            end
            grant[v]      = hit;
            grant_flit[v] = switch_flit[(v*n_ports + 32'(grant_port[v]))*n_fw +: n_fw];
            grant_type[v] = grant_flit[v][flit_width-1 -: flit_type_width];
            if (hit) begin
                switch_read[v*n_ports + 32'(grant_port[v])] = 1'b1;
                if (state[v] == IDLE) begin
                    owner_nxt[v] = grant_port[v];
                    last_nxt[v]  = grant_port[v];
                    if (grant_type[v] == FT_HEADER) begin
                        state_nxt[v] = LOCKED;
                    end
                end else if (grant_type[v] == FT_LAST) begin
                    state_nxt[v] = IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned v = 0; v < n_vch; v++) begin
                state[v] <= IDLE;
                owner[v] <= '0;
                last[v]  <= pw'(ports - 1);
            end
        end else begin
            for (int unsigned v = 0; v < n_vch; v++) begin
                state[v] <= state_nxt[v];
                owner[v] <= owner_nxt[v];
                last[v]  <= last_nxt[v];
            end
        end
    end

    // Per-vchannel FIFOs; storage is cleared so link_flit reads 0 after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned v = 0; v < n_vch; v++) begin
                for (int unsigned i = 0; i < n_depth; i++) begin
                    mem[v][i] <= '0;
                end
                rd_ptr[v] <= '0;
                wr_ptr[v] <= '0;
                count[v]  <= '0;
            end
        end else begin
            for (int unsigned v = 0; v < n_vch; v++) begin
                if (grant[v]) begin
                    mem[v][wr_ptr[v]] <= grant_flit[v];
                    wr_ptr[v] <= (wr_ptr[v] == aw'(fifo_length - 1)) ? '0 : wr_ptr[v] + 1'b1;
                end
                if (pop[v]) begin
                    rd_ptr[v] <= (rd_ptr[v] == aw'(fifo_length - 1)) ? '0 : rd_ptr[v] + 1'b1;
                end
                count[v] <= count[v] + cw'(grant[v]) - cw'(pop[v]);
            end
        end
    end

    // Link scheduler: show the head of FIFO cur, move on after a transfer or
    // when cur is empty. Stalled valid keeps cur, so the link stays stable.
    always_comb begin : scheduler
        int unsigned idx;
        logic        adv;
        logic        found;
        idx        = 0;
        adv        = 1'b0;
        found      = 1'b0;
        link_flit  = '0;
        link_valid = '0;
        pop        = '0;
        cur_nxt    = cur;
        for (int unsigned v = 0; v < n_vch; v++) begin
            if (vw'(v) == cur) begin
                link_flit     = mem[v][rd_ptr[v]];
                link_valid[v] = nonempty[v];
                pop[v]        = nonempty[v] && link_ready[v];
                adv           = !nonempty[v] || link_ready[v];
            end
        end
        if (adv) begin
            for (int unsigned k = 1; k < n_vch; k++) begin
                idx = (32'(cur) + k) % n_vch;
                if (!found && nonempty[idx]) begin
                    found   = 1'b1;
                    cur_nxt = vw'(idx);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur <= '0;
        end else begin
            cur <= cur_nxt;
        end
    end

`ifdef LISNOC_ROUTER_OUTPUT_CHECK_EN
    localparam logic [flit_type_width-1:0] FT_PAYLOAD = flit_type_width'(0);
    localparam logic [flit_type_width-1:0] FT_SINGLE  = flit_type_width'(3);

    logic [vchannels-1:0] err_q;

    // Flags a packet that does not start with HEADER/SINGLE, or one that
    // starts again while a packet is still open. The flit is accepted anyway.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= '0;
        end else begin
            for (int unsigned v = 0; v < n_vch; v++) begin
                if (grant[v] &&
                    ((state[v] == IDLE &&
                      (grant_type[v] == FT_PAYLOAD || grant_type[v] == FT_LAST)) ||
                     (state[v] == LOCKED &&
                      (grant_type[v] == FT_HEADER || grant_type[v] == FT_SINGLE)))) begin
                    err_q[v] <= 1'b1;
                end
            end
        end
    end

    assign protocol_error = err_q;
`else
    assign protocol_error = '0;
`endif

endmodule

// File: tb/tb_lisnoc_router_output_port.sv
module tb_lisnoc_router_output_port;

    localparam int DW = 32;
    localparam int TW = 2;
    localparam int FW = DW + TW;
    localparam int V  = 2;
    localparam int P  = 5;
    localparam int D  = 4;
    localparam int NS = V * P;

    localparam logic [1:0] T_PAYLOAD = 2'b00;
    localparam logic [1:0] T_HEADER  = 2'b01;
    localparam logic [1:0] T_LAST    = 2'b10;
    localparam logic [1:0] T_SINGLE  = 2'b11;

`ifdef LISNOC_ROUTER_OUTPUT_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic            clk;
    logic            rst;
    logic [NS-1:0]   switch_request;
    logic [FW*NS-1:0] switch_flit;
    logic [NS-1:0]   switch_read;
    logic [FW-1:0]   link_flit;
    logic [V-1:0]    link_valid;
    logic [V-1:0]    link_ready;
    logic [V-1:0]    protocol_error;

    lisnoc_router_output_port #(
        .flit_data_width(DW),
        .flit_type_width(TW),
        .vchannels(V),
        .ports(P),
        .fifo_length(D)
    ) dut (
        .clk(clk),
        .rst(rst),
        .switch_request(switch_request),
        .switch_flit(switch_flit),
        .switch_read(switch_read),
        .link_flit(link_flit),
        .link_valid(link_valid),
        .link_ready(link_ready),
        .protocol_error(protocol_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;

    // Stimulus sources (one flit queue per input/vchannel) and scoreboard.
    logic [FW-1:0] src_q [NS][$];
    logic [FW-1:0] exp_q [V][$];
    bit            granted [NS];
    bit            popped  [V];
    int            req_pct;
    int            rdy_mode [V];   // 0 low, 1 high, 2 random
    int            rd_cnt;

    // Reference model state, in terms of the arbitration rules.
    bit m_locked [V];
    int m_last   [V];
    int m_owner  [V];
    bit m_err    [V];
    int m_cur;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int v = 0; v < V; v++) begin
            exp_q[v].delete();
            popped[v]   = 1'b0;
            m_locked[v] = 1'b0;
            m_last[v]   = P - 1;
            m_owner[v]  = 0;
            m_err[v]    = 1'b0;
        end
        for (int s = 0; s < NS; s++) begin
            src_q[s].delete();
            granted[s] = 1'b0;
        end
        m_cur = 0;
        switch_request = '0;
    endtask

    task automatic push_flit(input int s, input logic [1:0] t);
        logic [FW-1:0] f;
        f = {t, 32'($urandom)};
        src_q[s].push_back(f);
    endtask

    task automatic push_pkt(input int s, input int len);
        for (int i = 0; i < len; i++) begin
            logic [1:0] t;
            if (len == 1)           t = T_SINGLE;
            else if (i == 0)        t = T_HEADER;
            else if (i == len - 1)  t = T_LAST;
            else                    t = T_PAYLOAD;
            push_flit(s, t);
        end
    endtask

    task automatic wait_idle(input int bound);
        int n;
        bit busy;
        req_pct = 100;
        for (int v = 0; v < V; v++) rdy_mode[v] = 1;
        n = 0;
        do begin
            @(negedge clk);
            #3;
            n++;
            busy = 1'b0;
            for (int s = 0; s < NS; s++) if (src_q[s].size() != 0) busy = 1'b1;
            for (int v = 0; v < V; v++) if (exp_q[v].size() != 0) busy = 1'b1;
        end while (busy && n < bound);
        checks++;
        if (busy) begin
            failures++;
            $display("FAIL drain_timeout actual=busy_after_%0d_cycles required=idle", n);
        end
    endtask

    // Driver: consume granted flits, present source heads, set link_ready.
    initial begin
        switch_request = '0;
        switch_flit    = '0;
        link_ready     = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int s = 0; s < NS; s++) begin
                if (granted[s]) begin
                    if (src_q[s].size() != 0) void'(src_q[s].pop_front());
                    granted[s] = 1'b0;
                end
            end
            for (int s = 0; s < NS; s++) begin
                if (src_q[s].size() != 0 && $urandom_range(99) < req_pct) begin
                    switch_request[s] = 1'b1;
                    switch_flit[s*FW +: FW] = src_q[s][0];
                end else begin
                    switch_request[s] = 1'b0;
                    switch_flit[s*FW +: FW] = {2'($urandom), 32'($urandom)};
                end
            end
            for (int v = 0; v < V; v++) begin
                link_ready[v] = (rdy_mode[v] == 2) ? 1'($urandom_range(1)) : (rdy_mode[v] == 1);
            end
        end
    end

    // Predictor: expected grants from the spec rules; pushes accepted flits
    // into the per-vchannel scoreboard queue.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                if (switch_read[0]) rd_cnt++;
                for (int v = 0; v < V; v++) begin
                    int gp;
                    bit full;
                    logic [P-1:0]  exp_rd;
                    logic [FW-1:0] f;
                    logic [1:0]    t;
                    full = (exp_q[v].size() + int'(popped[v])) >= D;
                    popped[v] = 1'b0;
                    gp = -1;
                    if (!full) begin
                        if (!m_locked[v]) begin
                            for (int k = 1; k <= P; k++) begin
                                int p;
                                p = (m_last[v] + k) % P;
                                if (gp < 0 && switch_request[v*P + p]) gp = p;
                            end
                        end else if (switch_request[v*P + m_owner[v]]) begin
                            gp = m_owner[v];
                        end
                    end
                    exp_rd = '0;
                    if (gp >= 0) exp_rd[gp] = 1'b1;
                    check($sformatf("switch_read_v%0d", v), 64'(switch_read[v*P +: P]), 64'(exp_rd));
                    check($sformatf("protocol_error_v%0d", v), 64'(protocol_error[v]), 64'(m_err[v]));
                    if (gp >= 0) begin
                        f = switch_flit[(v*P + gp)*FW +: FW];
                        t = f[FW-1 -: 2];
                        exp_q[v].push_back(f);
                        granted[v*P + gp] = 1'b1;
                        if (!m_locked[v]) begin
                            if (CHK_EN && (t == T_PAYLOAD || t == T_LAST)) m_err[v] = 1'b1;
                            m_last[v]   = gp;
                            m_owner[v]  = gp;
                            m_locked[v] = (t == T_HEADER);
                        end else begin
                            if (CHK_EN && (t == T_HEADER || t == T_SINGLE)) m_err[v] = 1'b1;
                            if (t == T_LAST) m_locked[v] = 1'b0;
                        end
                    end
                end
            end
        end
    end

    // Monitor: checks what the link shows and pops the scoreboard on transfer.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                bit ne [V];
                logic [V-1:0] ev;
                bit adv;
                bit found;
                for (int v = 0; v < V; v++) ne[v] = (exp_q[v].size() != 0);
                ev = '0;
                if (ne[m_cur]) ev[m_cur] = 1'b1;
                check("link_valid", 64'(link_valid), 64'(ev));
                adv = !ne[m_cur];
                if (ne[m_cur]) begin
                    check($sformatf("link_flit_v%0d", m_cur), 64'(link_flit), 64'(exp_q[m_cur][0]));
                    if (link_ready[m_cur]) begin
                        void'(exp_q[m_cur].pop_front());
                        popped[m_cur] = 1'b1;
                        adv = 1'b1;
                    end
                end
                if (adv) begin
                    found = 1'b0;
                    for (int k = 1; k < V; k++) begin
                        int c;
                        c = (m_cur + k) % V;
                        if (!found && ne[c]) begin
                            found = 1'b1;
                            m_cur = c;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;
        rd_cnt   = 0;
        req_pct  = 100;
        for (int v = 0; v < V; v++) rdy_mode[v] = 1;
        rst = 1'b0;
        model_reset();

        // Reset state.
        repeat (3) @(negedge clk);
        check("reset_link_valid", 64'(link_valid), 64'(0));
        check("reset_switch_read", 64'(switch_read), 64'(0));
        check("reset_protocol_error", 64'(protocol_error), 64'(0));
        check("reset_link_flit", 64'(link_flit), 64'(0));
        #3 rst = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_link_valid", 64'(link_valid), 64'(0));
        check("idle_switch_read", 64'(switch_read), 64'(0));
        #3;

        // Two packets on vchannel 0 from inputs 1 and 3: input 1 first, contiguous.
        push_pkt(1, 3);
        push_pkt(3, 3);
        wait_idle(100);

        // Backpressure: input 0 streams SINGLEs while ready is low.
        rdy_mode[0] = 0;
        for (int i = 0; i < 8; i++) push_flit(0, T_SINGLE);
        rd_cnt = 0;
        repeat (15) @(negedge clk);
        check("backpressure_reads", 64'(rd_cnt), 64'(4));
        check("backpressure_valid", 64'(link_valid), 64'(1));
        check("backpressure_switch_read", 64'(switch_read[P-1:0]), 64'(0));
        #3;
        wait_idle(100);

        // Both vchannels loaded, stalled on v0, then released.
        rdy_mode[0] = 0;
        rdy_mode[1] = 0;
        for (int i = 0; i < 3; i++) begin
            push_flit(0, T_SINGLE);
            push_flit(P, T_SINGLE);
        end
        repeat (8) @(negedge clk);
        check("stall_hold_valid", 64'(link_valid), 64'(1));
        #3;
        rdy_mode[0] = 1;
        rdy_mode[1] = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("alternate_%0d", i), 64'(link_valid), (i % 2 == 0) ? 64'(1) : 64'(2));
        end
        #3;
        wait_idle(100);

        // Framing error: PAYLOAD in IDLE, then clean packets; sticky until reset.
        push_flit(0, T_PAYLOAD);
        for (int i = 0; i < 10; i++) push_pkt(i % 2, 1 + (i % 4));
        wait_idle(300);
        check("proto_err_sticky", 64'(protocol_error[0]), 64'(CHK_EN));
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        check("proto_err_after_reset", 64'(protocol_error), 64'(0));
        #3 rst = 1'b1;

        // Randomised traffic on both vchannels.
        req_pct = 70;
        rdy_mode[0] = 2;
        rdy_mode[1] = 2;
        repeat (1500) begin
            @(negedge clk);
            #3;
            for (int s = 0; s < NS; s++) begin
                if (src_q[s].size() < 6 && $urandom_range(99) < 8) push_pkt(s, $urandom_range(1, 4));
            end
        end
        wait_idle(2000);

        // Reset mid-packet drops buffered flits and the lock.
        req_pct = 100;
        rdy_mode[0] = 2;
        rdy_mode[1] = 2;
        for (int s = 0; s < NS; s++) push_pkt(s, 4);
        repeat (6) @(negedge clk);
        #3 rst = 1'b0;
        model_reset();
        @(negedge clk);
        check("midreset_link_valid", 64'(link_valid), 64'(0));
        check("midreset_switch_read", 64'(switch_read), 64'(0));
        #3 rst = 1'b1;
        for (int s = 0; s < NS; s++) push_pkt(s, $urandom_range(1, 3));
        wait_idle(300);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
